// File: rtl/gpu_csr_ctrl.sv
// gpu_csr_ctrl: Avalon-MM control/status register block for the voxel GPU.
//
// Holds the CPU-written buffer-pointer and camera registers (live copy) and a
// shadow copy that the render pipeline consumes, so the CPU can stage the next
// frame while the current one renders. A three-state render FSM issues
// render-start pulses, queues one pending request, counts finished frames and
// raises a maskable, sticky interrupt.
//
// Ports:
//   clock, reset      system clock; asynchronous active-high reset
//   s1_*              Avalon-MM slave (word addressed, zero wait states)
//   render_start      one-cycle pulse to the pipeline (FSM in START)
//   render_done       one-cycle pulse from the pipeline, frame finished
//   cfg_buf           active buffer registers, reg i at [i*DATA_W +: DATA_W]
//   cfg_cam           active camera, vector v comp c at [(3*v+c)*DATA_W +: DATA_W]
//   irq               irq_pending & irq_en
//
// Register map (word addresses):
//   0x00..NUM_BUF_REGS-1   buffer registers, RW
//   0x0C FRAME_COUNT RO    0x0D STATUS RO {queued, irq_pending, busy}
//   0x0E IRQ_CTRL RW bit0  0x0F CMD WO (nonzero = request, zero = clear irq)
//   0x10 + 3*v + c         camera registers, RW
module gpu_csr_ctrl #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned NUM_BUF_REGS = 5,
    parameter int unsigned NUM_CAM_VEC  = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               s1_address,
    input  logic                            s1_read,
    input  logic                            s1_write,
    input  logic [DATA_W-1:0]               s1_writedata,
    output logic [DATA_W-1:0]               s1_readdata,
    output logic                            s1_waitrequest,
    output logic                            render_start,
    input  logic                            render_done,
    output logic [NUM_BUF_REGS*DATA_W-1:0]  cfg_buf,
    output logic [NUM_CAM_VEC*3*DATA_W-1:0] cfg_cam,
    output logic                            irq
);

    localparam int unsigned ADDR_FRAME   = 12;
    localparam int unsigned ADDR_STATUS  = 13;
    localparam int unsigned ADDR_IRQ     = 14;
    localparam int unsigned ADDR_CMD     = 15;
    localparam int unsigned CAM_BASE     = 16;
    localparam int unsigned NUM_CAM_REGS = 3 * NUM_CAM_VEC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] live_buf   [NUM_BUF_REGS];
    logic [DATA_W-1:0] live_cam   [NUM_CAM_REGS];
    logic [DATA_W-1:0] shadow_buf [NUM_BUF_REGS];
    logic [DATA_W-1:0] shadow_cam [NUM_CAM_REGS];

    logic [DATA_W-1:0] frame_count;
    logic              irq_pending;
    logic              irq_en;
    logic              queued;

    logic cmd_sel, req, clr, done_run, busy;

    // Reads have no side effects; the strobe is intentionally not consumed.
    logic s1_read_unused;
    assign s1_read_unused = s1_read;

    assign s1_waitrequest = 1'b0;
    assign cmd_sel  = s1_write && (s1_address == ADDR_W'(ADDR_CMD));
    assign req      = cmd_sel && (s1_writedata != '0);
    assign clr      = cmd_sel && (s1_writedata == '0);
    assign done_run = render_done && (state == RUN);
    assign busy     = (state != IDLE);

    assign render_start = (state == START);
    assign irq          = irq_pending & irq_en;

    // Render FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req || queued) next_state = START;
            START:   next_state = RUN;
            RUN:     if (render_done) next_state = (queued || req) ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control / status. The queued request is consumed on the edge that
    // enters START, so a request coinciding with render_done in RUN goes
    // straight into the new START without leaving queued set behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            queued      <= 1'b0;
            irq_pending <= 1'b0;
            irq_en      <= 1'b0;
            frame_count <= '0;
        end else begin
            if (next_state == START)
                queued <= 1'b0;
            else if (req && (state != IDLE))
                queued <= 1'b1;

            // set wins over a simultaneous clear
            if (done_run)
                irq_pending <= 1'b1;
            else if (clr)
                irq_pending <= 1'b0;

            if (s1_write && (s1_address == ADDR_W'(ADDR_IRQ)))
                irq_en <= s1_writedata[0];

            if (done_run)
                frame_count <= frame_count + 1'b1;
        end
    end

    // Live registers (CPU side)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BUF_REGS; i++) live_buf[i] <= '0;
            for (int unsigned i = 0; i < NUM_CAM_REGS; i++) live_cam[i] <= '0;
        end else if (s1_write) begin
            for (int unsigned i = 0; i < NUM_BUF_REGS; i++)
                if (s1_address == ADDR_W'(i)) live_buf[i] <= s1_writedata;
            for (int unsigned i = 0; i < NUM_CAM_REGS; i++)
                if (s1_address == ADDR_W'(CAM_BASE + i)) live_cam[i] <= s1_writedata;
        end
    end

    // Shadow registers (pipeline side), committed on entry to START
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BUF_REGS; i++) shadow_buf[i] <= '0;
            for (int unsigned i = 0; i < NUM_CAM_REGS; i++) shadow_cam[i] <= '0;
        end else if (next_state == START) begin
            for (int unsigned i = 0; i < NUM_BUF_REGS; i++) shadow_buf[i] <= live_buf[i];
            for (int unsigned i = 0; i < NUM_CAM_REGS; i++) shadow_cam[i] <= live_cam[i];
        end
    end

    for (genvar g = 0; g < NUM_BUF_REGS; g++) begin : g_buf
        assign cfg_buf[g*DATA_W +: DATA_W] = shadow_buf[g];
    end

    for (genvar g = 0; g < NUM_CAM_REGS; g++) begin : g_cam
        assign cfg_cam[g*DATA_W +: DATA_W] = shadow_cam[g];
    end

    // Read mux: always the live copy
    always_comb begin
        s1_readdata = '0;
        for (int unsigned i = 0; i < NUM_BUF_REGS; i++)
            if (s1_address == ADDR_W'(i)) s1_readdata = live_buf[i];
        for (int unsigned i = 0; i < NUM_CAM_REGS; i++)
            if (s1_address == ADDR_W'(CAM_BASE + i)) s1_readdata = live_cam[i];
        if (s1_address == ADDR_W'(ADDR_FRAME))
            s1_readdata = frame_count;
        if (s1_address == ADDR_W'(ADDR_STATUS))
            s1_readdata[2:0] = {queued, irq_pending, busy};
        if (s1_address == ADDR_W'(ADDR_IRQ))
            s1_readdata[0] = irq_en;
    end

endmodule

// File: tb/tb_gpu_csr_ctrl.sv
// Directed self-checking bench for gpu_csr_ctrl (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_gpu_csr_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   s1_address;
    logic         s1_read;
    logic         s1_write;
    logic [31:0]  s1_writedata;
    logic [31:0]  s1_readdata;
    logic         s1_waitrequest;
    logic         render_start;
    logic         render_done;
    logic [159:0] cfg_buf;
    logic [479:0] cfg_cam;
    logic         irq;

    int total = 0;
    int bad   = 0;

    gpu_csr_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (8),
        .NUM_BUF_REGS(5),
        .NUM_CAM_VEC (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s1_address    (s1_address),
        .s1_read       (s1_read),
        .s1_write      (s1_write),
        .s1_writedata  (s1_writedata),
        .s1_readdata   (s1_readdata),
        .s1_waitrequest(s1_waitrequest),
        .render_start  (render_start),
        .render_done   (render_done),
        .cfg_buf       (cfg_buf),
        .cfg_cam       (cfg_cam),
        .irq           (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        s1_address = a; s1_writedata = d; s1_write = 1'b1;
        @(negedge clock);
        s1_write = 1'b0; s1_writedata = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        s1_address = a; s1_read = 1'b1;
        #1;
        d = s1_readdata;
        s1_read = 1'b0;
    endtask

    task automatic done_pulse();
        render_done = 1'b1;
        @(negedge clock);
        render_done = 1'b0;
    endtask

    logic [31:0] d;
    int          starts;

    initial begin
        reset = 1'b1; s1_address = '0; s1_read = 1'b0; s1_write = 1'b0;
        s1_writedata = '0; render_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_rs", 32'(render_start), 0);
        chk("rst_irq", 32'(irq), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_rs", 32'(render_start), 0);
        chk("post_rst_irq", 32'(irq), 0);
        chk("waitreq", 32'(s1_waitrequest), 0);

        // all mapped and unmapped registers read 0
        for (int a = 0; a <= 30; a++) begin
            rd(8'(a), d);
            chk($sformatf("rst_rd_%02h", a), d, 0);
        end

        wr(8'h10, 32'h1234);
        rd(8'h10, d);          chk("cam_rdback", d, 32'h1234);
        chk("cam_not_active", 32'(cfg_cam != '0), 0);
        wr(8'h05, 32'hDEAD);
        rd(8'h05, d);          chk("unmapped_05", d, 0);
        wr(8'h0C, 32'h55);
        rd(8'h0C, d);          chk("frame_ro", d, 0);

        // first render
        wr(8'h00, 32'hA000);
        wr(8'h10, 32'h5);
        wr(8'h0F, 32'h1);
        chk("start1_rs", 32'(render_start), 1);
        chk("start1_buf0", cfg_buf[31:0], 32'hA000);
        chk("start1_camx", cfg_cam[31:0], 32'h5);
        rd(8'h0D, d);          chk("start1_status", d, 32'h1);
        @(negedge clock);
        chk("run1_rs", 32'(render_start), 0);

        // staged writes and coalesced requests while running
        wr(8'h00, 32'hB000);
        wr(8'h0F, 32'h1);
        wr(8'h0F, 32'h1);
        chk("run1_buf0_hold", cfg_buf[31:0], 32'hA000);
        rd(8'h0D, d);          chk("run1_status_q", d, 32'h5);
        done_pulse();
        chk("start2_rs", 32'(render_start), 1);
        chk("start2_buf0", cfg_buf[31:0], 32'hB000);
        rd(8'h0C, d);          chk("start2_frame", d, 32'h1);
        rd(8'h0D, d);          chk("start2_status", d, 32'h3);
        chk("start2_irq_masked", 32'(irq), 0);
        starts = 0;
        repeat (3) begin
            @(negedge clock);
            if (render_start) starts++;
        end
        chk("no_extra_start", 32'(starts), 0);
        done_pulse();
        rd(8'h0C, d);          chk("idle_frame2", d, 32'h2);
        rd(8'h0D, d);          chk("idle_status_pend", d, 32'h2);
        chk("pend_irq_masked", 32'(irq), 0);

        // enable/clear interrupt
        wr(8'h0E, 32'hFFFF_FFFF);
        chk("irq_enabled", 32'(irq), 1);
        rd(8'h0E, d);          chk("irqctrl_rd", d, 32'h1);
        rd(8'h0F, d);          chk("cmd_rd0", d, 0);
        wr(8'h0F, 32'h0);
        chk("irq_cleared", 32'(irq), 0);
        rd(8'h0C, d);          chk("clr_frame_same", d, 32'h2);

        // clear on the same edge as render_done: set wins
        wr(8'h0F, 32'h1);
        @(negedge clock);
        s1_address = 8'h0F; s1_writedata = '0; s1_write = 1'b1; render_done = 1'b1;
        @(negedge clock);
        s1_write = 1'b0; render_done = 1'b0;
        chk("clr_vs_done_irq", 32'(irq), 1);
        rd(8'h0D, d);          chk("clr_vs_done_status", d, 32'h2);
        rd(8'h0C, d);          chk("frame3", d, 32'h3);
        wr(8'h0F, 32'h0);
        chk("irq_clr2", 32'(irq), 0);

        // render_done in IDLE ignored
        done_pulse();
        rd(8'h0C, d);          chk("idle_done_frame", d, 32'h3);
        chk("idle_done_irq", 32'(irq), 0);

        // request on the same edge as render_done in RUN
        wr(8'h0F, 32'h1);
        @(negedge clock);
        s1_address = 8'h0F; s1_writedata = 32'h7; s1_write = 1'b1; render_done = 1'b1;
        @(negedge clock);
        s1_write = 1'b0; render_done = 1'b0;
        chk("req_done_rs", 32'(render_start), 1);
        rd(8'h0C, d);          chk("req_done_frame", d, 32'h4);
        @(negedge clock);
        done_pulse();
        rd(8'h0D, d);          chk("req_done_idle", d, 32'h2);
        wr(8'h0F, 32'h0);

        // reset mid-RUN with a queued request
        wr(8'h0F, 32'h1);
        @(negedge clock);
        wr(8'h0F, 32'h1);
        rd(8'h0D, d);          chk("pre_rst_status", d, 32'h5);
        reset = 1'b1;
        #1;
        chk("mid_rst_rs", 32'(render_start), 0);
        chk("mid_rst_irq", 32'(irq), 0);
        chk("mid_rst_buf", 32'(cfg_buf != '0), 0);
        chk("mid_rst_cam", 32'(cfg_cam != '0), 0);
        rd(8'h0D, d);          chk("mid_rst_status", d, 0);
        rd(8'h0C, d);          chk("mid_rst_frame", d, 0);
        @(negedge clock);
        reset = 1'b0;
        starts = 0;
        repeat (4) begin
            @(negedge clock);
            if (render_start) starts++;
        end
        chk("post_rst_no_start", 32'(starts), 0);

        // FRAME_COUNT wrap
        force dut.frame_count = 32'hFFFF_FFFF;
        #1;
        release dut.frame_count;
        rd(8'h0C, d);          chk("frame_preload", d, 32'hFFFF_FFFF);
        @(negedge clock);
        wr(8'h0F, 32'h1);
        @(negedge clock);
        done_pulse();
        rd(8'h0C, d);          chk("frame_wrap", d, 0);
        rd(8'h0D, d);          chk("wrap_status", d, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
